// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver: synchronizes the raw lines, deframes 11-bit frames and
// turns arrow/space make/break sequences into held-key levels.
module ps2_key_decoder #(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       key_left,
  output logic       key_right,
  output logic       key_down,
  output logic       key_rotate,
  output logic       key_drop,
  output logic       frame_valid,
  output logic [7:0] scan_code,
  output logic       parity_err
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t        state, state_nxt;
  logic          clk_s1, clk_s2, clk_prev;
  logic          dat_s1, dat_s2;
  logic          fall;
  logic          timeout;
  logic [CW-1:0] to_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          par_bit;
  logic          good, bad;
  logic          ext, brk;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_s1   <= 1'b1;
      clk_s2   <= 1'b1;
      clk_prev <= 1'b1;
      dat_s1   <= 1'b1;
      dat_s2   <= 1'b1;
    end else begin
      clk_s1   <= ps2_clk;
      clk_s2   <= clk_s1;
      clk_prev <= clk_s2;
      dat_s1   <= ps2_data;
      dat_s2   <= dat_s1;
    end
  end

  assign fall    = clk_prev & ~clk_s2;
  assign timeout = (state != IDLE) && (to_cnt == TO_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    good      = 1'b0;
    bad       = 1'b0;
    if (fall) begin
      unique case (state)
        IDLE:   if (!dat_s2) state_nxt = DATA;
        DATA:   if (bit_cnt == 3'd7) state_nxt = PARITY;
        PARITY: state_nxt = STOP;
        STOP: begin
          state_nxt = IDLE;
          // A low stop bit is a framing error and is dropped without any pulse.
          if (dat_s2) begin
            good = ^{shreg, par_bit};
            bad  = ~(^{shreg, par_bit});
          end
        end
        default: state_nxt = IDLE;
      endcase
    end else if (timeout) begin
      state_nxt = IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt      <= '0;
      bit_cnt     <= '0;
      shreg       <= '0;
      par_bit     <= 1'b0;
      frame_valid <= 1'b0;
      parity_err  <= 1'b0;
      scan_code   <= '0;
    end else begin
      if (fall || state == IDLE) to_cnt <= '0;
      else                       to_cnt <= to_cnt + CW'(1);
      if (fall) begin
        if (state == IDLE) bit_cnt <= '0;
        if (state == DATA) begin
          shreg   <= {dat_s2, shreg[7:1]};
          bit_cnt <= bit_cnt + 3'd1;
        end
        if (state == PARITY) par_bit <= dat_s2;
      end
      frame_valid <= good;
      parity_err  <= bad;
      if (good) scan_code <= shreg;
    end
  end

  // Prefix bytes only arm flags; the byte that follows applies them and clears them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ext        <= 1'b0;
      brk        <= 1'b0;
      key_left   <= 1'b0;
      key_right  <= 1'b0;
      key_down   <= 1'b0;
      key_rotate <= 1'b0;
      key_drop   <= 1'b0;
    end else if (frame_valid) begin
      case (scan_code)
        8'hE0: ext <= 1'b1;
        8'hF0: brk <= 1'b1;
        default: begin
          if (ext) begin
            case (scan_code)
              8'h6B: key_left   <= ~brk;
              8'h74: key_right  <= ~brk;
              8'h72: key_down   <= ~brk;
              8'h75: key_rotate <= ~brk;
              default: ;
            endcase
          end else if (scan_code == 8'h29) begin
            key_drop <= ~brk;
          end
          ext <= 1'b0;
          brk <= 1'b0;
        end
      endcase
    end
  end

endmodule
